// File: rtl/digital_clock_set.sv
// Settable hh:mm:ss core with 12/24-hour BCD display; outputs follow the registers combinationally.
// Optional alarm comparator is built when DIGITAL_CLOCK_ALARM_EN is defined.
module digital_clock_set #(
   parameter int CNT_NUM = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_mode,
   input  logic       key_inc,
   input  logic       mode_12h,
   output logic [7:0] hour_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       pm,
   output logic [1:0] edit_field,
   output logic       blink,
   output logic       sec_pulse
`ifdef DIGITAL_CLOCK_ALARM_EN
   ,
   input  logic [4:0] alarm_hour,
   input  logic [5:0] alarm_min,
   output logic       alarm
`endif
);

   localparam int CW = (CNT_NUM > 2) ? $clog2(CNT_NUM) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(CNT_NUM - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CNT_NUM / 2);

   typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [4:0]    hour, hour_nxt, hour12;
   logic [5:0]    min, min_nxt;
   logic [5:0]    sec;

   function automatic logic [7:0] to_bcd(input logic [6:0] v);
      return {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      edit_field = 2'd0;
      case (state)
         RUN: begin
            if (key_mode) state_nxt = SET_HOUR;
         end
         SET_HOUR: begin
            edit_field = 2'd1;
            if (key_mode) state_nxt = SET_MIN;
         end
         SET_MIN: begin
            edit_field = 2'd2;
            if (key_mode) state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   assign sec_pulse = (state == RUN) && (cnt == CNT_MAX);
   assign blink     = (state != RUN) && (cnt >= CNT_HALF);

   // Carry values a seconds tick would produce; shared by the counter and the alarm compare.
   always_comb begin
      min_nxt  = (min == 6'd59) ? 6'd0 : min + 6'd1;
      hour_nxt = hour;
      if (min == 6'd59) hour_nxt = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         hour <= '0;
         min  <= '0;
         sec  <= '0;
      end else begin
         cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
         case (state)
            RUN: begin
               if (sec_pulse) begin
                  if (sec == 6'd59) begin
                     sec  <= '0;
                     min  <= min_nxt;
                     hour <= hour_nxt;
                  end else begin
                     sec <= sec + 6'd1;
                  end
               end
            end
            SET_HOUR: begin
               if (!key_mode && key_inc) hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
            end
            SET_MIN: begin
               if (key_mode) begin
                  sec <= '0;
                  cnt <= '0;
               end else if (key_inc) begin
                  min <= min_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      hour12 = hour;
      if (hour == 5'd0)       hour12 = 5'd12;
      else if (hour > 5'd12)  hour12 = hour - 5'd12;
   end

   assign pm       = (hour >= 5'd12);
   assign hour_bcd = to_bcd({2'b00, mode_12h ? hour12 : hour});
   assign min_bcd  = to_bcd({1'b0, min});
   assign sec_bcd  = to_bcd({1'b0, sec});

`ifdef DIGITAL_CLOCK_ALARM_EN
   logic alarm_hit;
   assign alarm_hit = sec_pulse && (sec == 6'd59) &&
                      (min_nxt == alarm_min) && (hour_nxt == alarm_hour);

   // Alarm always rises on a minute boundary, so the next minute rollover ends its 60 s.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        alarm <= 1'b0;
      else if (key_mode || key_inc)      alarm <= 1'b0;
      else if (alarm_hit)                alarm <= 1'b1;
      else if (sec_pulse && sec == 6'd59) alarm <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_digital_clock_set.sv
// Bench for digital_clock_set with CNT_NUM = 4; reference model tracks time as seconds-of-day.
module tb_digital_clock_set;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_mode = 1'b0;
   logic       key_inc = 1'b0;
   logic       mode_12h = 1'b0;
   logic [7:0] hour_bcd, min_bcd, sec_bcd;
   logic       pm, blink, sec_pulse;
   logic [1:0] edit_field;
`ifdef DIGITAL_CLOCK_ALARM_EN
   logic [4:0] alarm_hour = 5'd0;
   logic [5:0] alarm_min = 6'd1;
   logic       alarm;
`endif

   int checks = 0;
   int failures = 0;

   // reference model state
   int m_t, m_cnt, m_st, m_alarm;

   digital_clock_set #(.CNT_NUM(N)) dut (
      .clk(clk), .rst_n(rst_n), .key_mode(key_mode), .key_inc(key_inc),
      .mode_12h(mode_12h), .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
      .pm(pm), .edit_field(edit_field), .blink(blink), .sec_pulse(sec_pulse)
`ifdef DIGITAL_CLOCK_ALARM_EN
      , .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm(alarm)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] bcd(input int v);
      return 8'((v / 10) * 16 + (v % 10));
   endfunction

   function automatic logic [7:0] exp_hour_bcd();
      int h;
      h = m_t / 3600;
      if (mode_12h) h = (h % 12 == 0) ? 12 : h % 12;
      return bcd(h);
   endfunction

   task automatic model_reset();
      m_t = 0; m_cnt = 0; m_st = 0; m_alarm = 0;
   endtask

   task automatic model_step(input logic km, input logic ki);
      int h, m;
      h = m_t / 3600;
      m = (m_t / 60) % 60;
      if (m_st == 0) begin
         if (m_cnt == N - 1) begin
            m_t = (m_t + 1) % 86400;
`ifdef DIGITAL_CLOCK_ALARM_EN
            if (m_t == alarm_hour * 3600 + alarm_min * 60) m_alarm = 1;
            else if (m_t % 60 == 0)                        m_alarm = 0;
`endif
         end
         m_cnt = (m_cnt + 1) % N;
         if (km) m_st = 1;
      end else begin
         m_cnt = (m_cnt + 1) % N;
         if (km) begin
            if (m_st == 1) m_st = 2;
            else begin
               m_st = 0;
               m_t = m_t - (m_t % 60);
               m_cnt = 0;
            end
         end else if (ki) begin
            if (m_st == 1) m_t = m_t - h * 3600 + ((h + 1) % 24) * 3600;
            else           m_t = m_t - m * 60 + ((m + 1) % 60) * 60;
         end
      end
      if (km || ki) m_alarm = 0;
   endtask

   task automatic tick(input logic km, input logic ki);
      key_mode = km;
      key_inc  = ki;
      @(posedge clk);
      model_step(km, ki);
      @(negedge clk);
      key_mode = 1'b0;
      key_inc  = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      mode_12h = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (hour_bcd !== 8'h00) begin failures++; $display("FAIL reset_hour24 got=%h exp=00", hour_bcd); end
      checks++; if (min_bcd !== 8'h00 || sec_bcd !== 8'h00) begin failures++; $display("FAIL reset_min_sec got=%h/%h exp=00/00", min_bcd, sec_bcd); end
      checks++; if ({pm, blink, sec_pulse, edit_field} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {pm, blink, sec_pulse, edit_field}); end
      mode_12h = 1'b1;
      #1;
      checks++; if (hour_bcd !== 8'h12) begin failures++; $display("FAIL reset_hour12 got=%h exp=12", hour_bcd); end
      mode_12h = 1'b0;
`ifdef DIGITAL_CLOCK_ALARM_EN
      checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL reset_alarm got=%b exp=0", alarm); end
`endif
   endtask

   task automatic test_run();
      do_reset();
      repeat (N - 1) tick(0, 0);
      checks++; if (sec_pulse !== 1'b1) begin failures++; $display("FAIL first_sec_pulse got=%b exp=1", sec_pulse); end
      tick(0, 0);
      checks++; if (sec_bcd !== 8'h01 || sec_pulse !== 1'b0) begin failures++; $display("FAIL first_second got=%h/%b exp=01/0", sec_bcd, sec_pulse); end
      repeat (240 - N) tick(0, 0);
      checks++; if (min_bcd !== 8'h01 || sec_bcd !== 8'h00) begin failures++; $display("FAIL one_minute got=%h:%h exp=01:00", min_bcd, sec_bcd); end
   endtask

   task automatic test_wrap();
      do_reset();
      tick(1, 0);
      repeat (23) tick(0, 1);
      tick(1, 0);
      repeat (59) tick(0, 1);
      tick(1, 0);
      repeat (59 * N) tick(0, 0);
      checks++; if ({hour_bcd, min_bcd, sec_bcd} !== 24'h235959) begin failures++; $display("FAIL preload got=%h exp=235959", {hour_bcd, min_bcd, sec_bcd}); end
      repeat (N) tick(0, 0);
      checks++; if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000) begin failures++; $display("FAIL midnight24 got=%h exp=000000", {hour_bcd, min_bcd, sec_bcd}); end
      mode_12h = 1'b1;
      #1;
      checks++; if (hour_bcd !== 8'h12 || pm !== 1'b0) begin failures++; $display("FAIL midnight12 got=%h pm=%b exp=12 pm=0", hour_bcd, pm); end
      mode_12h = 1'b0;
   endtask

   task automatic test_set_edit();
      do_reset();
      tick(1, 0);
      checks++; if (edit_field !== 2'd1) begin failures++; $display("FAIL edit_hour got=%0d exp=1", edit_field); end
      repeat (14) tick(0, 1);
      mode_12h = 1'b1;
      #1;
      checks++; if (hour_bcd !== 8'h02 || pm !== 1'b1) begin failures++; $display("FAIL hour14_12h got=%h pm=%b exp=02 pm=1", hour_bcd, pm); end
      mode_12h = 1'b0;
      #1;
      checks++; if (hour_bcd !== 8'h14) begin failures++; $display("FAIL hour14_24h got=%h exp=14", hour_bcd); end
      tick(1, 0);
      checks++; if (edit_field !== 2'd2) begin failures++; $display("FAIL edit_min got=%0d exp=2", edit_field); end
      repeat (61) tick(0, 1);
      checks++; if (min_bcd !== 8'h01 || hour_bcd !== 8'h14) begin failures++; $display("FAIL min_wrap got=%h:%h exp=14:01", hour_bcd, min_bcd); end
      for (int i = 0; i < 2 * N; i++) begin
         tick(0, 0);
         checks++; if (blink !== ((m_st != 0) && (m_cnt >= N / 2))) begin failures++; $display("FAIL blink_set got=%b exp=%b", blink, !blink); end
      end
      tick(1, 0);
      checks++; if (edit_field !== 2'd0 || sec_bcd !== 8'h00) begin failures++; $display("FAIL leave_set got=%0d/%h exp=0/00", edit_field, sec_bcd); end
      for (int i = 0; i < 2 * N; i++) begin
         checks++; if (blink !== 1'b0) begin failures++; $display("FAIL blink_run got=%b exp=0", blink); end
         tick(0, 0);
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      tick(1, 0);
      repeat (3) tick(0, 1);
      tick(1, 1);
      checks++; if (edit_field !== 2'd2 || hour_bcd !== 8'h03) begin failures++; $display("FAIL mode_wins got=%0d/%h exp=2/03", edit_field, hour_bcd); end
   endtask

   task automatic test_reset_mid_edit();
      do_reset();
      tick(1, 0);
      repeat (7) tick(0, 1);
      tick(1, 0);
      repeat (5) tick(0, 1);
      checks++; if ({hour_bcd, min_bcd} !== 16'h0705) begin failures++; $display("FAIL pre_reset got=%h exp=0705", {hour_bcd, min_bcd}); end
      rst_n = 1'b0;
      #1;
      checks++; if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000) begin failures++; $display("FAIL async_reset_time got=%h exp=000000", {hour_bcd, min_bcd, sec_bcd}); end
      checks++; if (edit_field !== 2'd0 || sec_pulse !== 1'b0) begin failures++; $display("FAIL async_reset_flags got=%0d/%b exp=0/0", edit_field, sec_pulse); end
      do_reset();
   endtask

`ifdef DIGITAL_CLOCK_ALARM_EN
   task automatic test_alarm();
      alarm_hour = 5'd0;
      alarm_min  = 6'd1;
      do_reset();
      repeat (239) tick(0, 0);
      checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL alarm_early got=%b exp=0", alarm); end
      tick(0, 0);
      checks++; if (alarm !== 1'b1 || min_bcd !== 8'h01) begin failures++; $display("FAIL alarm_rise got=%b min=%h exp=1 min=01", alarm, min_bcd); end
      tick(0, 1);
      checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL alarm_key_clear got=%b exp=0", alarm); end
      do_reset();
      repeat (240) tick(0, 0);
      repeat (59 * N) tick(0, 0);
      checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL alarm_hold got=%b exp=1", alarm); end
      repeat (N) tick(0, 0);
      checks++; if (alarm !== 1'b0 || min_bcd !== 8'h02) begin failures++; $display("FAIL alarm_timeout got=%b min=%h exp=0 min=02", alarm, min_bcd); end
   endtask
`endif

   task automatic test_random();
      logic km, ki;
      logic exp_blink, exp_pulse;
`ifdef DIGITAL_CLOCK_ALARM_EN
      alarm_hour = 5'd0;
      alarm_min  = 6'd2;
`endif
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         km = ($urandom_range(0, 39) == 0);
         ki = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 15) == 0) mode_12h = ~mode_12h;
         tick(km, ki);
         exp_blink = (m_st != 0) && (m_cnt >= N / 2);
         exp_pulse = (m_st == 0) && (m_cnt == N - 1);
         checks++; if (hour_bcd !== exp_hour_bcd()) begin failures++; $display("FAIL rnd_hour cyc=%0d got=%h exp=%h", i, hour_bcd, exp_hour_bcd()); end
         checks++; if (min_bcd !== bcd((m_t / 60) % 60) || sec_bcd !== bcd(m_t % 60)) begin failures++; $display("FAIL rnd_min_sec cyc=%0d got=%h:%h exp=%h:%h", i, min_bcd, sec_bcd, bcd((m_t / 60) % 60), bcd(m_t % 60)); end
         checks++; if (pm !== (m_t >= 12 * 3600)) begin failures++; $display("FAIL rnd_pm cyc=%0d got=%b exp=%b", i, pm, m_t >= 12 * 3600); end
         checks++; if (edit_field !== 2'(m_st)) begin failures++; $display("FAIL rnd_edit cyc=%0d got=%0d exp=%0d", i, edit_field, m_st); end
         checks++; if (blink !== exp_blink || sec_pulse !== exp_pulse) begin failures++; $display("FAIL rnd_strobes cyc=%0d got=%b%b exp=%b%b", i, blink, sec_pulse, exp_blink, exp_pulse); end
`ifdef DIGITAL_CLOCK_ALARM_EN
         checks++; if (alarm !== 1'(m_alarm)) begin failures++; $display("FAIL rnd_alarm cyc=%0d got=%b exp=%0d", i, alarm, m_alarm); end
`endif
      end
      mode_12h = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_run();
      test_wrap();
      test_set_edit();
      test_same_cycle();
      test_reset_mid_edit();
`ifdef DIGITAL_CLOCK_ALARM_EN
      test_alarm();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
